bit_reverse_accel_core: RTL and testbench
=========================================

Name: bit_reverse_accel_core

Overview:
Compute core of the bit-reverse accelerator. It sits between the input and output register slices of the accelerator's stream path. Under ap_ctrl-style start/done control, it consumes exactly len words from the upstream stream, bit-reverses each word, and emits them through a single stalling pipeline register to the downstream stream. One word per cycle sustained; one cycle of latency.

Parameters:
DataWidth, 32, stream word width in bits
CountWidth, 16, width of the per-transaction word count len

Ports:
ap_clk  input  1  clock; all state updates on the rising edge
ap_rst  input  1  reset, asynchronous, active-high
ap_start  input  1  start request; sampled only in IDLE
len  input  CountWidth  words to process; sampled in the cycle the transaction starts
ap_done  output  1  one-cycle pulse when the transaction completes
ap_ready  output  1  one-cycle pulse, same cycle as ap_done
ap_idle  output  1  high while in IDLE
in_data  input  DataWidth  upstream word
in_vld  input  1  upstream valid
in_ack  output  1  core accepts in_data this cycle
out_data  output  DataWidth  bit-reversed word (registered)
out_vld  output  1  out_data valid (registered)
out_ack  input  1  downstream accepts out_data

Behaviour:
- Reset (async assert): state=IDLE, out_vld=0, out_data=0, rem_cnt=0, ap_done=0, ap_ready=0, ap_idle=1. Reset release is synchronous-safe; the first active edge after deassert sees IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ap_idle=1, in_ack=0.
  - On ap_start=1: rem_cnt<=len, go to RUN. This applies for len=0 as well.
- RUN:
  - ap_idle=0.
  - in_ack = (rem_cnt!=0) & (~out_vld | out_ack). This is combinational from out_ack. That is legal because both neighbours are register slices whose ack is registered, so no combinational loop forms.
  - Accept = in_vld & in_ack. On accept: out_data<=bitrev(in_data) (out_data[i]=in_data[DataWidth-1-i]), out_vld<=1, rem_cnt<=rem_cnt-1.
  - Without accept: if out_ack, then out_vld<=0 and out_data holds its value.
  - When out_vld & ~out_ack, out_data and out_vld hold (no drop, no overwrite).
  - Exit to DONE when rem_cnt==0 and (~out_vld | out_ack), i.e. the last word is leaving or already left. For len=0 this is the first RUN cycle, with no words consumed.
- DONE (exactly one cycle):
  - ap_done=1, ap_ready=1, in_ack=0, then go to IDLE.
  - out_vld is guaranteed 0 in DONE.
- ap_start in RUN or DONE is ignored; len is not re-sampled. Back-to-back transactions: ap_start held high restarts from IDLE. Minimum gap between the last output word and the next accepted input is 2 cycles (DONE plus IDLE).
- Words beyond len are never consumed (in_ack=0 once rem_cnt==0). Extra upstream data stays in the upstream slice.
- rem_cnt is a CountWidth-bit down-counter, so the maximum transaction is 2^CountWidth-1 words and it never wraps.
- Latency: a word accepted at edge t is on out_data with out_vld=1 after edge t, and held until out_ack.
- Throughput: 1 word/cycle with out_ack tied high.
- Async reset mid-transaction: the partial output word is discarded, counters clear, and the core returns to IDLE with no ap_done pulse.

Test Plan:
1. Reset, ap_start with len=3, words 0x00000001, 0x12345678, 0xF0000000 back-to-back, out_ack=1 -> out_data 0x80000000, 0x1E6A2C48, 0x0000000F on consecutive cycles, each 1 cycle after input accept; ap_done and ap_ready high for exactly 1 cycle after the last output; ap_idle returns high.
2. len=2, out_ack=0 for 5 cycles after the first output -> out_data holds 0x80000000 with out_vld=1, in_ack=0, nothing lost; on release both words emerge in order and ap_done pulses once.
3. len=0, ap_start pulse -> in_ack never asserts, out_vld stays 0, ap_done pulses 2 cycles after start.
4. Upstream offers 4 words with len=2 -> only 2 accepted; in_ack=0 afterwards; 3rd word remains pending at upstream.
5. Random in_vld/out_ack patterns, len=1000 -> scoreboard shows 1000 correctly bit-reversed words, in order, no duplicates.
6. Assert ap_rst asynchronously mid-transaction with out_vld=1 -> out_vld and ap_done go 0 immediately, ap_idle goes 1; the next transaction (len=1, 0xAAAAAAAA) yields 0x55555555.

Source files
------------

// File: rtl/bit_reverse_accel_core_if.sv
// rtl/bit_reverse_accel_core_if.sv - control and stream bundle for the bit-reverse compute core
//
// Signals:
//   ap_start, len          : transaction request and word count (master -> slave)
//   ap_done, ap_ready      : one-cycle completion pulses (slave -> master)
//   ap_idle                : core is in IDLE (slave -> master)
//   in_data, in_vld        : upstream word and valid (master -> slave)
//   in_ack                 : core takes in_data this cycle (slave -> master)
//   out_data, out_vld      : bit-reversed word and valid (slave -> master)
//   out_ack                : downstream takes out_data (master -> slave)
interface bit_reverse_accel_core_if #(
    parameter int DataWidth  = 32,
    parameter int CountWidth = 16
);
    logic                  ap_start;
    logic [CountWidth-1:0] len;
    logic                  ap_done;
    logic                  ap_ready;
    logic                  ap_idle;
    logic [DataWidth-1:0]  in_data;
    logic                  in_vld;
    logic                  in_ack;
    logic [DataWidth-1:0]  out_data;
    logic                  out_vld;
    logic                  out_ack;

    modport master (
        output ap_start, len, in_data, in_vld, out_ack,
        input  ap_done, ap_ready, ap_idle, in_ack, out_data, out_vld
    );

    modport slave (
        input  ap_start, len, in_data, in_vld, out_ack,
        output ap_done, ap_ready, ap_idle, in_ack, out_data, out_vld
    );
endinterface

// File: rtl/bit_reverse_accel_core.sv
// rtl/bit_reverse_accel_core.sv - start/done controlled stream core that bit-reverses len words
//
// Ports:
//   ap_clk : clock, rising edge
//   ap_rst : asynchronous active-high reset
//   bus    : slave side of bit_reverse_accel_core_if (control, upstream and downstream streams)
module bit_reverse_accel_core #(
    parameter int DataWidth  = 32,
    parameter int CountWidth = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    bit_reverse_accel_core_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CountWidth-1:0] rem_cnt;
    logic [DataWidth-1:0]  out_data_q;
    logic                  out_vld_q;
    logic [DataWidth-1:0]  rev_data;
    logic                  out_free;
    logic                  in_ack_c;
    logic                  accept;

    // The output register can take a new word when it is empty or its word leaves this cycle.
    assign out_free = ~out_vld_q | bus.out_ack;
    // Combinational path from out_ack is safe: both neighbours are register slices.
    assign in_ack_c = (state_q == S_RUN) & (rem_cnt != '0) & out_free;
    assign accept   = bus.in_vld & in_ack_c;

    always_comb begin
        rev_data = '0;
        for (int i = 0; i < DataWidth; i++) begin
            rev_data[i] = bus.in_data[DataWidth-1-i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.ap_start) state_d = S_RUN;
            // Leave only once the final word has gone, so out_vld is clear in DONE.
            S_RUN:  if ((rem_cnt == '0) && out_free) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rem_cnt    <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && bus.ap_start) begin
                rem_cnt <= bus.len;
            end else if (accept) begin
                rem_cnt <= rem_cnt - CountWidth'(1);
            end

            if (accept) begin
                out_data_q <= rev_data;
                out_vld_q  <= 1'b1;
            end else if (bus.out_ack) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ack   = in_ack_c;
    assign bus.out_data = out_data_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.ap_idle  = (state_q == S_IDLE);
    assign bus.ap_done  = (state_q == S_DONE);
    assign bus.ap_ready = (state_q == S_DONE);

endmodule

// File: tb/tb_bit_reverse_accel_core.sv
// tb/tb_bit_reverse_accel_core.sv - self-checking bench for bit_reverse_accel_core
module tb_bit_reverse_accel_core;

    logic ap_clk;
    logic ap_rst;

    bit_reverse_accel_core_if #(.DataWidth(32), .CountWidth(16)) bus ();

    bit_reverse_accel_core #(.DataWidth(32), .CountWidth(16)) u_dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.slave)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    int          acc_cnt;
    int          out_cnt;
    int          done_cnt;
    int          n_checks;
    int          n_fails;
    bit          vld_rand;
    bit          ack_rand;
    logic        ack_val;

    function automatic logic [31:0] ref_rev(input logic [31:0] x);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            r = (r * 32'd2) + ((x >> i) & 32'd1);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, score the handshakes that fire at the next rising edge.
    task automatic tick();
        bus.in_vld  = (src_q.size() != 0) && (vld_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        bus.in_data = (src_q.size() != 0) ? src_q[0] : 32'd0;
        bus.out_ack = ack_rand ? ($urandom_range(0, 1) == 1) : ack_val;
        #1;
        if (bus.ap_done || bus.ap_ready) begin
            check("ready_with_done", {63'd0, bus.ap_ready}, {63'd0, bus.ap_done});
        end
        if (bus.ap_done) done_cnt++;
        if (bus.out_vld && bus.out_ack) begin
            out_cnt++;
            if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
            else check("out_word", {32'd0, bus.out_data}, {32'd0, exp_q.pop_front()});
        end
        if (bus.in_vld && bus.in_ack) begin
            exp_q.push_back(ref_rev(src_q.pop_front()));
            acc_cnt++;
        end
        @(negedge ap_clk);
    endtask

    task automatic run_until_done(input int limit, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int a0;
        int o0;
        logic [31:0] w;
        n_checks = 0; n_fails = 0; acc_cnt = 0; out_cnt = 0; done_cnt = 0;
        vld_rand = 1'b0; ack_rand = 1'b0; ack_val = 1'b1;
        ap_rst = 1'b1;
        bus.ap_start = 1'b0; bus.len = '0; bus.in_data = '0; bus.in_vld = 1'b0; bus.out_ack = 1'b1;
        @(negedge ap_clk);
        check("rst_idle",  {63'd0, bus.ap_idle}, 64'd1);
        check("rst_vld",   {63'd0, bus.out_vld}, 64'd0);
        check("rst_data",  {32'd0, bus.out_data}, 64'd0);
        check("rst_done",  {63'd0, bus.ap_done}, 64'd0);
        check("rst_ready", {63'd0, bus.ap_ready}, 64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // 1: three words back-to-back, downstream always ready
        src_q = '{32'h00000001, 32'h12345678, 32'hF0000000};
        bus.ap_start = 1'b1; bus.len = 16'd3;
        tick();
        bus.ap_start = 1'b0;
        check("t1_busy", {63'd0, bus.ap_idle}, 64'd0);
        tick();
        check("t1_vld0", {63'd0, bus.out_vld}, 64'd1);
        check("t1_w0", {32'd0, bus.out_data}, 64'h80000000);
        tick();
        check("t1_w1", {32'd0, bus.out_data}, 64'h1E6A2C48);
        tick();
        check("t1_w2", {32'd0, bus.out_data}, 64'h0000000F);
        tick();
        check("t1_done", {63'd0, bus.ap_done}, 64'd1);
        check("t1_vld_in_done", {63'd0, bus.out_vld}, 64'd0);
        tick();
        check("t1_done_pulse", {63'd0, bus.ap_done}, 64'd0);
        check("t1_idle", {63'd0, bus.ap_idle}, 64'd1);
        check("t1_outs", 64'(out_cnt), 64'd3);

        // 2: downstream stalls for 5 cycles after the first output
        src_q = '{32'h00000001, 32'h00000003};
        o0 = out_cnt;
        bus.ap_start = 1'b1; bus.len = 16'd2;
        tick();
        bus.ap_start = 1'b0;
        tick();
        ack_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_vld", {63'd0, bus.out_vld}, 64'd1);
            check("t2_hold_data", {32'd0, bus.out_data}, 64'h80000000);
            check("t2_hold_ack", {63'd0, bus.in_ack}, 64'd0);
        end
        ack_val = 1'b1;
        run_until_done(20, "t2_done_once");
        tick();
        check("t2_no_second_done", {63'd0, bus.ap_done}, 64'd0);
        check("t2_outs", 64'(out_cnt - o0), 64'd2);

        // 3: zero-length transaction, a word is offered but must not be taken
        src_q = '{32'hDEADBEEF};
        a0 = acc_cnt;
        bus.ap_start = 1'b1; bus.len = 16'd0;
        tick();
        bus.ap_start = 1'b0;
        check("t3_no_ack", {63'd0, bus.in_ack}, 64'd0);
        tick();
        check("t3_done", {63'd0, bus.ap_done}, 64'd1);
        check("t3_vld", {63'd0, bus.out_vld}, 64'd0);
        tick();
        check("t3_idle", {63'd0, bus.ap_idle}, 64'd1);
        check("t3_none_taken", 64'(acc_cnt - a0), 64'd0);
        src_q.delete();

        // 4: four words offered, only len=2 consumed
        src_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        a0 = acc_cnt;
        bus.ap_start = 1'b1; bus.len = 16'd2;
        tick();
        bus.ap_start = 1'b0;
        run_until_done(20, "t4_done");
        tick();
        check("t4_taken", 64'(acc_cnt - a0), 64'd2);
        check("t4_left", 64'(src_q.size()), 64'd2);
        check("t4_pending", {32'd0, src_q[0]}, 64'h33333333);
        check("t4_ack_off", {63'd0, bus.in_ack}, 64'd0);
        src_q.delete();

        // 5: random valid/ack patterns, 1000 words plus 3 surplus
        for (int i = 0; i < 1003; i++) begin
            w = $urandom;
            src_q.push_back(w);
        end
        a0 = acc_cnt; o0 = out_cnt;
        vld_rand = 1'b1; ack_rand = 1'b1;
        bus.ap_start = 1'b1; bus.len = 16'd1000;
        tick();
        bus.ap_start = 1'b0;
        run_until_done(20000, "t5_done");
        vld_rand = 1'b0; ack_rand = 1'b0; ack_val = 1'b1;
        check("t5_taken", 64'(acc_cnt - a0), 64'd1000);
        check("t5_outs", 64'(out_cnt - o0), 64'd1000);
        check("t5_drained", 64'(exp_q.size()), 64'd0);
        check("t5_left", 64'(src_q.size()), 64'd3);
        src_q.delete();
        tick();

        // 6: asynchronous reset with a word held in the output register
        src_q = '{32'h0000FFFF, 32'h12345678, 32'h00000001};
        ack_val = 1'b0;
        bus.ap_start = 1'b1; bus.len = 16'd3;
        tick();
        bus.ap_start = 1'b0;
        tick();
        check("t6_vld_before", {63'd0, bus.out_vld}, 64'd1);
        #2;
        ap_rst = 1'b1;
        #1;
        check("t6_vld_cleared", {63'd0, bus.out_vld}, 64'd0);
        check("t6_data_cleared", {32'd0, bus.out_data}, 64'd0);
        check("t6_no_done", {63'd0, bus.ap_done}, 64'd0);
        check("t6_idle", {63'd0, bus.ap_idle}, 64'd1);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        exp_q.delete();
        src_q.delete();
        @(negedge ap_clk);
        check("t6_still_idle", {63'd0, bus.ap_idle}, 64'd1);
        ack_val = 1'b1;
        src_q = '{32'hAAAAAAAA};
        bus.ap_start = 1'b1; bus.len = 16'd1;
        tick();
        bus.ap_start = 1'b0;
        tick();
        check("t6_vld_after", {63'd0, bus.out_vld}, 64'd1);
        check("t6_word", {32'd0, bus.out_data}, 64'h55555555);
        run_until_done(20, "t6_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
